// File: rtl/add_accum_seq.sv
// ---------------------------------------------------------------------------
// add_accum_seq
//
// Purpose: sums CNT operands per transaction by steering them through an
// external N-bit adder. The accumulator feeds adder input a, the incoming
// operand feeds adder input b, and the adder sum is written back on every
// accepted operand. The finished sum is presented with a valid/ready
// handshake. A sticky carry flag records whether any add overflowed.
//
// Configuration macro: ADD_ACCUM_SAT_EN
//   undefined (default) : acc wraps modulo 2^N.
//   defined             : the first carry-out pins acc at all-ones for the
//                         rest of the transaction.
//
// Parameters:
//   N    operand / accumulator width (matches the external adder)
//   CNT  operands summed per transaction (2..255)
//
// Ports:
//   clk         sole clock; all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   start       begin a transaction (sampled only in IDLE)
//   in_valid    din holds a valid operand
//   in_ready    block accepts din this cycle (ACC state)
//   din         operand
//   add_a       to adder a   (acc register)
//   add_b       to adder b   (din, combinational)
//   add_cin     to adder cin (constant 0)
//   add_sum     from adder sum
//   add_cout    from adder carry-out
//   out_valid   result available (DONE state)
//   out_ready   consumer takes the result
//   acc_out     accumulated result (acc register)
//   carry_flag  sticky: any add_cout seen on an accept in this transaction
//   busy        high in ACC or DONE
// ---------------------------------------------------------------------------
module add_accum_seq #(
  parameter int N   = 8,
  parameter int CNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] din,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] acc_out,
  output logic         carry_flag,
  output logic         busy
);

  // Wide enough to hold the value CNT itself.
  localparam int CW = $clog2(CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          carry_q;

  logic          start_txn;
  logic          accept;
  logic [N-1:0]  acc_next;

  // Moore outputs decoded straight from the state register.
  assign in_ready   = (state == ACC);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign add_a      = acc;
  assign add_b      = din;
  assign add_cin    = 1'b0;
  assign acc_out    = acc;
  assign carry_flag = carry_q;

  assign start_txn = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;

`ifdef ADD_ACCUM_SAT_EN
  // carry_q is already sticky for the transaction, so it doubles as the
  // "saturated" marker: once set, acc stays at all-ones.
  assign acc_next = (add_cout || carry_q) ? {N{1'b1}} : add_sum;
`else
  assign acc_next = add_sum;
`endif

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)                   state_n = ACC;
      ACC:     if (accept && cnt == LAST)   state_n = DONE;
      DONE:    if (out_ready)               state_n = IDLE;
      default:                              state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (start_txn) begin
      acc     <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      acc     <= acc_next;
      cnt     <= cnt + CW'(1);
      carry_q <= carry_q | add_cout;
    end
  end

endmodule

// File: tb/tb_add_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_add_accum_seq
//
// Self-checking bench for add_accum_seq (N=8, CNT=4). Models the external
// adder as a+b+cin, applies a table of directed transactions, a few
// hand-written sequences (backpressure, mid-transaction reset), and random
// transactions checked against an arithmetic reference (total of operands).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_add_accum_seq;

  localparam int N   = 8;
  localparam int CNT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] din;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] acc_out;
  logic         carry_flag;
  logic         busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // External adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  add_accum_seq #(.N(N), .CNT(CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .carry_flag (carry_flag),
    .busy       (busy)
  );

  typedef logic [N-1:0] ops_t [CNT];

  typedef struct {
    ops_t         ops;
    int           gap;        // idle in_valid cycles before each operand
    bit           early_rdy;  // out_ready held high before the result
    logic [N-1:0] exp_acc;
    logic         exp_carry;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the result depends only on the true sum of the operands.
  // Carries can only occur if that sum reaches 2^N.
  function automatic logic [N:0] model(input ops_t ops);
    int total = 0;
    logic [N-1:0] r;
    for (int i = 0; i < CNT; i++) total += int'(ops[i]);
`ifdef ADD_ACCUM_SAT_EN
    r = (total >= (1 << N)) ? {N{1'b1}} : N'(total);
`else
    r = N'(total);
`endif
    return {(total >= (1 << N)) ? 1'b1 : 1'b0, r};
  endfunction

  // Runs start + CNT operands; returns at the falling edge after the last
  // accept, where out_valid must already be high.
  task automatic feed(input string name, input ops_t ops, input int gap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < CNT; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        din      = 8'hee;
        @(negedge clk);
        if (g == 0) check({name, " in_ready idle"}, 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      din      = ops[i];
      #1;
      if (i == 0) check({name, " add_b"}, 32'(add_b), 32'(ops[i]));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " in_ready done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    out_ready = v.early_rdy;
    feed(name, v.ops, v.gap);
    check({name, " acc_out"}, 32'(acc_out), 32'(v.exp_acc));
    check({name, " carry"}, 32'(carry_flag), 32'(v.exp_carry));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " idle out_valid"}, 32'(out_valid), 32'd0);
    check({name, " idle busy"}, 32'(busy), 32'd0);
    check({name, " retain acc"}, 32'(acc_out), 32'(v.exp_acc));
  endtask

  vec_t vecs [8];
  vec_t rv;
  logic [N:0] m;

  initial begin
    // Directed table; the REQ-034 overflow case depends on the build.
    vecs[0] = '{ops: '{8'd10, 8'd20, 8'd30, 8'd40}, gap: 0, early_rdy: 0, exp_acc: 8'd100, exp_carry: 1'b0};
`ifdef ADD_ACCUM_SAT_EN
    vecs[1] = '{ops: '{8'd200, 8'd100, 8'd0, 8'd0}, gap: 0, early_rdy: 0, exp_acc: 8'd255, exp_carry: 1'b1};
    vecs[4] = '{ops: '{8'd255, 8'd255, 8'd255, 8'd255}, gap: 0, early_rdy: 0, exp_acc: 8'd255, exp_carry: 1'b1};
    vecs[5] = '{ops: '{8'd64, 8'd64, 8'd64, 8'd64}, gap: 1, early_rdy: 1, exp_acc: 8'd255, exp_carry: 1'b1};
    vecs[7] = '{ops: '{8'd255, 8'd1, 8'd0, 8'd0}, gap: 0, early_rdy: 0, exp_acc: 8'd255, exp_carry: 1'b1};
`else
    vecs[1] = '{ops: '{8'd200, 8'd100, 8'd0, 8'd0}, gap: 0, early_rdy: 0, exp_acc: 8'd44, exp_carry: 1'b1};
    vecs[4] = '{ops: '{8'd255, 8'd255, 8'd255, 8'd255}, gap: 0, early_rdy: 0, exp_acc: 8'd252, exp_carry: 1'b1};
    vecs[5] = '{ops: '{8'd64, 8'd64, 8'd64, 8'd64}, gap: 1, early_rdy: 1, exp_acc: 8'd0, exp_carry: 1'b1};
    vecs[7] = '{ops: '{8'd255, 8'd1, 8'd0, 8'd0}, gap: 0, early_rdy: 0, exp_acc: 8'd0, exp_carry: 1'b1};
`endif
    vecs[2] = '{ops: '{8'd5, 8'd5, 8'd5, 8'd5}, gap: 2, early_rdy: 0, exp_acc: 8'd20, exp_carry: 1'b0};
    vecs[3] = '{ops: '{8'd0, 8'd0, 8'd0, 8'd0}, gap: 0, early_rdy: 1, exp_acc: 8'd0, exp_carry: 1'b0};
    vecs[6] = '{ops: '{8'd63, 8'd64, 8'd64, 8'd64}, gap: 0, early_rdy: 0, exp_acc: 8'd255, exp_carry: 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    #12;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset acc_out", 32'(acc_out), 32'd0);
    check("reset add_a", 32'(add_a), 32'd0);
    check("reset carry", 32'(carry_flag), 32'd0);
    check("add_cin", 32'(add_cin), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // in_valid outside ACC must not touch the accumulator.
    in_valid = 1'b1; din = 8'd77;
    @(negedge clk);
    in_valid = 1'b0;
    check("idle in_valid ignored", 32'(acc_out), 32'd0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held, start ignored, then release.
    out_ready = 1'b0;
    feed("bp", '{8'd5, 8'd5, 8'd5, 8'd5}, 0);
    for (int c = 0; c < 3; c++) begin
      start = (c == 1);
      @(negedge clk);
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp acc stable", 32'(acc_out), 32'd20);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp back to idle", 32'(busy), 32'd0);
    check("bp retain", 32'(acc_out), 32'd20);
    @(negedge clk);
    check("bp start not latched", 32'(busy), 32'd0);

    // Reset mid-transaction after two accepts.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; din = 8'd10;
    @(negedge clk);
    din = 8'd20;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-rst acc", 32'(acc_out), 32'd30);
    #2 rst = 1'b1;
    #1;
    check("rst acc_out", 32'(acc_out), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    feed("post-rst", '{8'd1, 8'd1, 8'd1, 8'd1}, 0);
    check("post-rst acc", 32'(acc_out), 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while DONE: no result afterwards.
    feed("done-rst", '{8'd9, 8'd9, 8'd9, 8'd9}, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("done-rst no out_valid", 32'(out_valid), 32'd0);
    check("done-rst acc", 32'(acc_out), 32'd0);

    // Random transactions against the arithmetic reference.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < CNT; i++) rv.ops[i] = N'($urandom_range(0, 255));
      rv.gap       = int'($urandom_range(0, 2));
      rv.early_rdy = 1'($urandom_range(0, 1));
      m            = model(rv.ops);
      rv.exp_acc   = m[N-1:0];
      rv.exp_carry = m[N];
      run_vec($sformatf("rnd%0d", t), rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/add_accum_seq.md
ADD_ACCUM_SEQ -- requirements
Module: add_accum_seq

Interface
REQ-001 SHALL have parameter N, default 8: operand/accumulator width, matching the downstream adder size.
REQ-002 SHALL have parameter CNT, default 4: operands summed per transaction (legal 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a transaction; sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  din holds a valid operand.
REQ-007 SHALL have port in_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port din  input  N  operand.
REQ-009 SHALL have port add_a  output  N  to adder a; equals acc register.
REQ-010 SHALL have port add_b  output  N  to adder b; equals din combinationally.
REQ-011 SHALL have port add_cin  output  1  to adder cin; constant 0.
REQ-012 SHALL have port add_sum  input  N  from adder sum, combinational.
REQ-013 SHALL have port add_cout  input  1  from adder cout, combinational.
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  consumer takes result.
REQ-016 SHALL have port acc_out  output  N  accumulated result (acc register).
REQ-017 SHALL have port carry_flag  output  1  sticky: any add_cout=1 during transaction.
REQ-018 SHALL have port busy  output  1  high in ACC or DONE.

Function
REQ-019 SHALL implement FSM states IDLE, ACC, DONE; encoding free.
REQ-020 IDLE: start=1 -> acc<=0, cnt<=0, carry_flag<=0, next ACC; else stay.
REQ-021 ACC: in_ready=1; accept = in_valid & in_ready; on accept acc<=add_sum, carry_flag<=carry_flag|add_cout, cnt<=cnt+1.
REQ-022 ACC: accept with cnt==CNT-1 -> next DONE; cycles with in_valid=0 SHALL change no state.
REQ-023 DONE: out_valid=1, in_ready=0, acc_out and carry_flag stable; out_ready=1 -> next IDLE.
REQ-024 out_valid SHALL rise the cycle after the CNT-th accept (1-cycle latency); out_ready may be high beforehand.
REQ-025 start SHALL be ignored in ACC and DONE; in_valid ignored outside ACC.
REQ-026 cnt width SHALL be ceil(log2(CNT+1)); acc wraps modulo 2^N unless REQ-031 applies.
REQ-027 acc_out and carry_flag SHALL retain their values in IDLE after handshake until next start.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, acc=0, cnt=0, carry_flag=0; outputs in_ready=0, out_valid=0, busy=0, acc_out=0, add_a=0.
REQ-029 rst asserted mid-ACC or mid-DONE SHALL discard the partial/pending result; no out_valid after release.
REQ-030 First start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro ADD_ACCUM_SAT_EN defined: on accept with add_cout=1, acc<={N{1'b1}} and acc held at all-ones for remaining operands of the transaction; carry_flag still set.
REQ-032 Macro ADD_ACCUM_SAT_EN undefined: acc<=add_sum always (modulo wrap); no saturation logic synthesised.

Verification (N=8, CNT=4, external adder a+b+cin)
REQ-033 start; din 10,20,30,40 back-to-back -> out_valid cycle after 4th accept, acc_out=100, carry_flag=0.
REQ-034 din 200,100,0,0 -> without macro acc_out=44, carry_flag=1; with ADD_ACCUM_SAT_EN acc_out=255, carry_flag=1.
REQ-035 din 5,5,5,5 with in_valid low 2 cycles between each -> acc_out=20; only 4 accepts counted.
REQ-036 Result ready, out_ready low 3 cycles, start pulsed -> out_valid held, acc_out=20 stable, start ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst pulsed after 2 accepts (acc=30) -> same cycle acc_out=0, in_ready=0, busy=0; new start, 1,1,1,1 -> acc_out=4.
